// File: rtl/addfloat_dispatch_if.sv
// Operand/run handshake bundle between the feeder and the float adder core.
// Signals keep the feeder's port names; slave = feeder, master = driver side.
interface addfloat_dispatch_if;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [31:0] i_data;
  logic        o_run_req;
  logic [31:0] o_run_input_a_0;
  logic        i_run_busy;

  modport slave (
    input  i_data_valid,
    input  i_data,
    input  i_run_busy,
    output o_data_ready,
    output o_run_req,
    output o_run_input_a_0
  );

  modport master (
    output i_data_valid,
    output i_data,
    output i_run_busy,
    input  o_data_ready,
    input  o_run_req,
    input  o_run_input_a_0
  );
endinterface

// File: rtl/addfloat_dispatch.sv
// Operand FIFO + run_req/run_busy issue FSM for the float adder core.
// Ports: clock, reset_n, ce, i_clear, bus (slave), o_idle, counters, o_error.
module addfloat_dispatch #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             i_clear,
  addfloat_dispatch_if.slave bus,
  output logic             o_idle,
  output logic [CNT_W-1:0] o_issue_count,
  output logic [CNT_W-1:0] o_done_count,
  output logic             o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e           state_q;
  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic [TW-1:0]    timer_q;
  logic             req_q;
  logic [31:0]      a0_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] issue_cnt_d;
  logic [CNT_W-1:0] done_cnt_q;
  logic [CNT_W-1:0] done_cnt_d;
  logic             err_q;
  logic             err_d;

  logic full;
  logic empty;
  logic push;
  logic issue;
  logic tmo;
  logic done_ev;

  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;

  // Ready looks at full only, so a full FIFO
  // never accepts even when a pop coincides.
  assign bus.o_data_ready = ce & ~full;

  assign push  = ce & bus.i_data_valid & ~full;
  assign issue = ce & (state_q == IDLE)
               & ~empty & ~bus.i_run_busy;

  assign tmo     = (state_q == WAIT_ACK)
                 & ~bus.i_run_busy
                 & (timer_q == TW'(TIMEOUT-1));
  assign done_ev = (state_q == WAIT_DONE)
                 & ~bus.i_run_busy;

  // Clear wins over a same-cycle increment.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    err_d       = err_q;
    if (i_clear) begin
      issue_cnt_d = '0;
      done_cnt_d  = '0;
      err_d       = 1'b0;
    end else begin
      if (issue)   issue_cnt_d = issue_cnt_q + 1'b1;
      if (done_ev) done_cnt_d  = done_cnt_q + 1'b1;
      if (tmo)     err_d       = 1'b1;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= bus.i_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      req_q       <= 1'b0;
      a0_q        <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else if (ce) begin
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      err_q       <= err_d;

      if (push) wptr_q <= wptr_q + 1'b1;
      if (issue) rptr_q <= rptr_q + 1'b1;
      case ({push, issue})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      unique case (state_q)
        IDLE: begin
          req_q <= 1'b0;
          if (issue) begin
            state_q <= WAIT_ACK;
            req_q   <= 1'b1;
            a0_q    <= mem_q[rptr_q];
            timer_q <= '0;
          end
        end
        WAIT_ACK: begin
          req_q <= 1'b0;
          if (bus.i_run_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmo) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          req_q <= 1'b0;
          if (done_ev) state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_run_req       = req_q;
  assign bus.o_run_input_a_0 = a0_q;

  assign o_idle        = (state_q == IDLE) & empty;
  assign o_issue_count = issue_cnt_q;
  assign o_done_count  = done_cnt_q;
  assign o_error       = err_q;

endmodule

// File: tb/tb_addfloat_dispatch.sv
// Directed bench for addfloat_dispatch with a queue scoreboard.
// A forked monitor pops expected operands on every run request.
module tb_addfloat_dispatch;

  logic        clock;
  logic        reset_n;
  logic        ce;
  logic        i_clear;
  logic        o_idle;
  logic [15:0] o_issue_count;
  logic [15:0] o_done_count;
  logic        o_error;

  addfloat_dispatch_if bus ();

  addfloat_dispatch dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ce            (ce),
    .i_clear       (i_clear),
    .bus           (bus),
    .o_idle        (o_idle),
    .o_issue_count (o_issue_count),
    .o_done_count  (o_done_count),
    .o_error       (o_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core model: busy rises on the edge after req,
  // stays high blen cycles. Manual mode overrides it.
  logic       core_busy;
  logic [4:0] bcnt;
  logic       never;
  logic       manual;
  logic       man_busy;
  int         blen;

  initial begin
    core_busy = 1'b0;
    bcnt      = '0;
  end

  always @(posedge clock) begin
    if (core_busy) begin
      if (bcnt <= 5'd1) core_busy <= 1'b0;
      else bcnt <= bcnt - 5'd1;
    end else if (bus.o_run_req && !never) begin
      core_busy <= 1'b1;
      bcnt      <= 5'(blen);
    end
  end

  assign bus.i_run_busy = manual ? man_busy : core_busy;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q [$];
  logic        prev_req;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, expv);
    end
  endfunction

  task automatic do_reset();
    reset_n          = 1'b0;
    ce               = 1'b1;
    i_clear          = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic push(input logic [31:0] d);
    bit ok;
    ok = 0;
    bus.i_data_valid = 1'b1;
    bus.i_data       = d;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_data_ready) begin
        exp_q.push_back(d);
        ok = 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    bus.i_data_valid = 1'b0;
    if (!ok) chk("push_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle(input string nm,
                           input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (o_idle) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    chk(nm, 32'(ok), 1);
  endtask

  task automatic wait_req(input string nm,
                          input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (bus.o_run_req) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    chk(nm, 32'(ok), 1);
  endtask

  initial begin
    int k;
    n_tests  = 0;
    n_fail   = 0;
    prev_req = 1'b0;
    never    = 1'b0;
    manual   = 1'b0;
    man_busy = 1'b0;
    blen     = 8;
    reset_n  = 1'b0;
    ce       = 1'b1;
    i_clear  = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;

    fork
      forever begin
        @(negedge clock);
        if (reset_n) begin
          chk("req_width",
              32'(prev_req & bus.o_run_req), 0);
          if (bus.o_run_req) begin
            chk("req_expected",
                32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
              chk("a0_operand",
                  bus.o_run_input_a_0,
                  exp_q.pop_front());
          end
        end
        prev_req = bus.o_run_req;
      end
    join_none

    // Reset state
    #2;
    chk("rst_req", 32'(bus.o_run_req), 0);
    chk("rst_a0", bus.o_run_input_a_0, 0);
    chk("rst_issue", 32'(o_issue_count), 0);
    chk("rst_done", 32'(o_done_count), 0);
    chk("rst_err", 32'(o_error), 0);
    chk("rst_idle", 32'(o_idle), 1);
    do_reset();

    // 1: single job
    push(32'h3F80_0000);
    wait_idle("t1_idle", 100);
    chk("t1_issue", 32'(o_issue_count), 1);
    chk("t1_done", 32'(o_done_count), 1);
    chk("t1_err", 32'(o_error), 0);

    // 2: fill FIFO while core is busy
    do_reset();
    manual   = 1'b1;
    man_busy = 1'b1;
    push(32'h1);
    push(32'h2);
    push(32'h3);
    push(32'h4);
    chk("t2_full_ready",
        32'(bus.o_data_ready), 0);
    manual = 1'b0;
    push(32'h5);
    wait_idle("t2_idle", 300);
    chk("t2_issue", 32'(o_issue_count), 5);
    chk("t2_done", 32'(o_done_count), 5);
    chk("t2_err", 32'(o_error), 0);

    // 3: core never acknowledges
    do_reset();
    never = 1'b1;
    push(32'h4000_0000);
    push(32'h4040_0000);
    wait_req("t3_req_a", 10);
    k = 0;
    while (!o_error && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("t3_tmo_cycles", 32'(k), 8);
    chk("t3_err", 32'(o_error), 1);
    @(negedge clock);
    wait_req("t3_req_b", 3);
    wait_idle("t3_idle", 40);
    chk("t3_issue", 32'(o_issue_count), 2);
    chk("t3_done", 32'(o_done_count), 0);
    chk("t3_err_sticky", 32'(o_error), 1);
    never = 1'b0;

    // 4: ce freeze in WAIT_DONE
    do_reset();
    manual   = 1'b1;
    man_busy = 1'b0;
    push(32'h4120_0000);
    wait_req("t4_req", 10);
    man_busy = 1'b1;
    @(negedge clock);
    ce               = 1'b0;
    man_busy         = 1'b0;
    bus.i_data_valid = 1'b1;
    bus.i_data       = 32'hDEAD_BEEF;
    repeat (10) begin
      @(negedge clock);
      chk("t4_frz_done", 32'(o_done_count), 0);
      chk("t4_frz_idle", 32'(o_idle), 0);
      chk("t4_frz_rdy",
          32'(bus.o_data_ready), 0);
    end
    ce               = 1'b1;
    bus.i_data_valid = 1'b0;
    @(negedge clock);
    chk("t4_done", 32'(o_done_count), 1);
    chk("t4_issue", 32'(o_issue_count), 1);
    chk("t4_idle", 32'(o_idle), 1);

    // 5: async reset during WAIT_DONE
    do_reset();
    manual   = 1'b1;
    man_busy = 1'b0;
    push(32'h10);
    wait_req("t5_req", 10);
    man_busy = 1'b1;
    push(32'h11);
    push(32'h12);
    push(32'h13);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_req", 32'(bus.o_run_req), 0);
    chk("t5_a0", bus.o_run_input_a_0, 0);
    chk("t5_issue", 32'(o_issue_count), 0);
    chk("t5_done", 32'(o_done_count), 0);
    chk("t5_err", 32'(o_error), 0);
    chk("t5_idle", 32'(o_idle), 1);
    exp_q.delete();
    man_busy = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("t5_issue_after",
        32'(o_issue_count), 0);
    chk("t5_idle_after", 32'(o_idle), 1);

    // 6: issue counter wrap, clear vs done
    do_reset();
    force dut.issue_cnt_q = 16'hFFFF;
    repeat (2) @(negedge clock);
    release dut.issue_cnt_q;
    @(negedge clock);
    chk("t6_preload",
        32'(o_issue_count), 32'hFFFF);
    manual   = 1'b1;
    man_busy = 1'b0;
    push(32'h4200_0000);
    wait_req("t6_req", 10);
    chk("t6_wrap", 32'(o_issue_count), 0);
    man_busy = 1'b1;
    @(negedge clock);
    man_busy = 1'b0;
    i_clear  = 1'b1;
    @(negedge clock);
    i_clear = 1'b0;
    chk("t6_done_clr",
        32'(o_done_count), 0);
    chk("t6_err_clr", 32'(o_error), 0);
    chk("t6_idle", 32'(o_idle), 1);

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
